// File: rtl/bdd_tree_loader.sv
// Byte-stream loader that fills the coefficient/child node SRAMs and raises tree_valid once a consistent tree is resident.
// Optional trailer checksum: define BDD_LOADER_CHECKSUM_EN.
module bdd_tree_loader #(
  parameter int ADDR_WIDTH  = 6,
  parameter int DEPTH       = 64,
  parameter int COEFF_WIDTH = 48,
  parameter int CHILD_WIDTH = 18
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [ADDR_WIDTH-1:0]  coeff_addr,
  output logic                   coeff_write,
  output logic [COEFF_WIDTH-1:0] coeff_data,
  output logic [ADDR_WIDTH-1:0]  child_addr,
  output logic                   child_write,
  output logic [CHILD_WIDTH-1:0] child_data,
  output logic                   busy,
  output logic                   tree_valid,
  output logic                   err,
  output logic [ADDR_WIDTH:0]    node_count
);
  localparam int         NW         = ADDR_WIDTH + 1;
  localparam int         HALF       = CHILD_WIDTH / 2;
  localparam logic [2:0] COEFF_LAST = 3'(COEFF_WIDTH / 8 - 1);
  localparam logic [2:0] CHILD_LAST = 3'd2;

  typedef enum logic [2:0] {
    IDLE, HDR, COEFF, CHILD, WRITE, DONE, ERR
`ifdef BDD_LOADER_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

  state_t                  state, next_state;
  logic [2:0]              byte_cnt;
  logic [ADDR_WIDTH-1:0]   node_idx;
  logic [COEFF_WIDTH-1:0]  coeff_sr;
  logic [CHILD_WIDTH-9:0]  child_sr;
  logic                    xfer, start_ok, hdr_ok, ptr_err, last_node;

`ifdef BDD_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  localparam state_t AFTER_LAST = CSUM;
`else
  localparam state_t AFTER_LAST = DONE;
`endif

  // A child half is a dangling pointer when it is not a class leaf and points past the last node.
  function automatic logic ptr_bad(input logic [HALF-1:0] h, input logic [NW-1:0] n);
    return !h[HALF-1] && (int'(h[HALF-2:0]) >= int'(n));
  endfunction

  assign xfer      = in_valid && in_ready;
  assign start_ok  = (next_state == HDR) && (state != HDR);
  assign hdr_ok    = (in_data != 8'd0) && (int'(in_data) <= DEPTH);
  assign ptr_err   = ptr_bad(child_data[CHILD_WIDTH-1:HALF], node_count) ||
                     ptr_bad(child_data[HALF-1:0], node_count);
  assign last_node = (int'(node_idx) == int'(node_count) - 1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    case (state)
      IDLE, DONE, ERR: if (start) next_state = HDR;
      HDR: begin
        in_ready = 1'b1;
        if (in_valid) next_state = hdr_ok ? COEFF : ERR;
      end
      COEFF: begin
        in_ready = 1'b1;
        if (in_valid && byte_cnt == COEFF_LAST) next_state = CHILD;
      end
      CHILD: begin
        in_ready = 1'b1;
        if (in_valid && byte_cnt == CHILD_LAST) next_state = WRITE;
      end
      WRITE: begin
        if (ptr_err)        next_state = ERR;
        else if (last_node) next_state = AFTER_LAST;
        else                next_state = COEFF;
      end
`ifdef BDD_LOADER_CHECKSUM_EN
      CSUM: begin
        in_ready = 1'b1;
        if (in_valid) next_state = ((csum ^ in_data) == 8'd0) ? DONE : ERR;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      coeff_addr  <= '0;
      coeff_write <= 1'b0;
      coeff_data  <= '0;
      child_addr  <= '0;
      child_write <= 1'b0;
      child_data  <= '0;
      busy        <= 1'b0;
      tree_valid  <= 1'b0;
      err         <= 1'b0;
      node_count  <= '0;
      byte_cnt    <= '0;
      node_idx    <= '0;
      coeff_sr    <= '0;
      child_sr    <= '0;
    end else begin
      coeff_write <= (next_state == WRITE);
      child_write <= (next_state == WRITE);
      if (start_ok) begin
        err        <= 1'b0;
        tree_valid <= 1'b0;
        busy       <= 1'b1;
        node_idx   <= '0;
        byte_cnt   <= '0;
      end
      if (next_state == DONE && state != DONE) begin
        tree_valid <= 1'b1;
        busy       <= 1'b0;
      end
      if (next_state == ERR && state != ERR) begin
        err  <= 1'b1;
        busy <= 1'b0;
      end
      if (xfer) begin
        case (state)
          HDR: node_count <= in_data[NW-1:0];
          COEFF: begin
            coeff_sr <= {coeff_sr[COEFF_WIDTH-9:0], in_data};
            byte_cnt <= (byte_cnt == COEFF_LAST) ? 3'd0 : byte_cnt + 3'd1;
          end
          CHILD: begin
            child_sr <= {child_sr[CHILD_WIDTH-17:0], in_data};
            if (byte_cnt == CHILD_LAST) begin
              // Buses are loaded once per node so they stay stable while the next record streams in.
              byte_cnt   <= 3'd0;
              coeff_addr <= node_idx;
              child_addr <= node_idx;
              coeff_data <= coeff_sr;
              child_data <= {child_sr, in_data};
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
          default: ;
        endcase
      end
      if (state == WRITE && next_state == COEFF) node_idx <= node_idx + ADDR_WIDTH'(1);
    end
  end

`ifdef BDD_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n || start_ok) csum <= 8'd0;
    else if (xfer)          csum <= csum ^ in_data;
  end
`endif

endmodule

// File: tb/tb_bdd_tree_loader.sv
// Randomized scoreboard bench for bdd_tree_loader: a stream-level model queues expected SRAM writes and load outcomes.
module tb_bdd_tree_loader;
  localparam int AW    = 6;
  localparam int DEPTH = 64;
  localparam int CW    = 48;
  localparam int HW    = 18;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] coeff_addr, child_addr;
  logic          coeff_write, child_write;
  logic [CW-1:0] coeff_data;
  logic [HW-1:0] child_data;
  logic          busy, tree_valid, err;
  logic [AW:0]   node_count;

  bdd_tree_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .COEFF_WIDTH(CW), .CHILD_WIDTH(HW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .coeff_addr(coeff_addr), .coeff_write(coeff_write),
    .coeff_data(coeff_data), .child_addr(child_addr), .child_write(child_write),
    .child_data(child_data), .busy(busy), .tree_valid(tree_valid), .err(err),
    .node_count(node_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [CW-1:0] coeff;
    logic [HW-1:0] child;
  } wr_t;

  typedef struct {
    bit done;
    bit err;
    int n;
    int lat;
  } out_t;

  wr_t  wq[$];
  out_t oq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit bad_ptr(input logic [8:0] h, input int n);
    return (h[8] == 1'b0) && (int'(h[7:0]) >= n);
  endfunction

  // Decodes a whole byte stream the way the loader should, queues the expected writes and
  // final outcome, and returns how many bytes the loader is expected to consume.
  function automatic int model(input logic [7:0] s[$], input bit full_rate);
    int n, p;
    logic [7:0]  x;
    logic [23:0] v;
    wr_t  w;
    out_t o;
    n = int'(s[0]);
    p = 1;
    x = s[0];
    o.done = 1'b0; o.err = 1'b0; o.n = 0; o.lat = 0;
    if (n == 0 || n > DEPTH) begin
      o.err = 1'b1;
      oq.push_back(o);
      return 1;
    end
    for (int i = 0; i < n; i++) begin
      w.addr  = AW'(i);
      w.coeff = {s[p], s[p+1], s[p+2], s[p+3], s[p+4], s[p+5]};
      v       = {s[p+6], s[p+7], s[p+8]};
      w.child = v[17:0];
      for (int k = 0; k < 9; k++) x ^= s[p+k];
      p += 9;
      wq.push_back(w);
      if (bad_ptr(v[17:9], n) || bad_ptr(v[8:0], n)) begin
        o.err = 1'b1;
        oq.push_back(o);
        return p;
      end
    end
`ifdef BDD_LOADER_CHECKSUM_EN
    x ^= s[p];
    p++;
    if (x != 8'd0) begin
      o.err = 1'b1;
      oq.push_back(o);
      return p;
    end
    o.lat = full_rate ? 2 + 10 * n : 0;
`else
    o.lat = full_rate ? 1 + 10 * n : 0;
`endif
    o.done = 1'b1;
    o.n    = n;
    oq.push_back(o);
    return p;
  endfunction

  function automatic logic [8:0] rand_half(input int n, input int bad_pct);
    int r;
    r = int'($urandom_range(99));
    if (r < 30) return {1'b1, 8'($urandom)};
    if (r < 30 + bad_pct) return {1'b0, ($urandom_range(1) == 1) ? 8'(n) : 8'($urandom_range(255, n))};
    return {1'b0, ($urandom_range(1) == 1) ? 8'(n - 1) : 8'($urandom_range(n - 1, 0))};
  endfunction

  task automatic add_trailer(inout logic [7:0] s[$], input bit flip);
`ifdef BDD_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'd0;
    foreach (s[k]) x ^= s[k];
    s.push_back(x ^ {7'd0, flip});
`else
    if (flip) s.push_back(8'hA5);
`endif
  endtask

  task automatic build(input int n, input int bad_pct, input bit flip, output logic [7:0] s[$]);
    logic [23:0] v;
    s = {};
    s.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 6; b++) s.push_back(8'($urandom));
      v = {6'($urandom), rand_half(n, bad_pct), rand_half(n, bad_pct)};
      s.push_back(v[23:16]);
      s.push_back(v[15:8]);
      s.push_back(v[7:0]);
    end
    add_trailer(s, flip);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_state", {busy, err, tree_valid}, 3'b100);
  endtask

  // gap 0: full rate; 1: in_valid low every other cycle; 2: random idle cycles.
  task automatic send(input logic [7:0] s[$], input int count, input int gap, input bit poke);
    int t, g;
    for (int i = 0; i < count; i++) begin
      g = (gap == 0) ? 0 : (gap == 1) ? 1 : int'($urandom_range(2));
      repeat (g) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = s[i];
      start    = poke && (i == 4);
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin
        t++;
        @(negedge clk);
      end
      if (!in_ready) begin
        n_vec++;
        n_bad++;
        $display("FAIL byte_accept: byte %0d never accepted, in_ready=%0b want 1", i, in_ready);
        in_valid = 1'b0;
        start    = 1'b0;
        return;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (busy) begin
      n_vec++;
      n_bad++;
      $display("FAIL load_end: busy=%0b after 200 cycles, want 0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_load(input logic [7:0] s[$], input int gap, input bit poke);
    int used;
    used = model(s, gap == 0);
    do_start();
    send(s, used, gap, poke);
    wait_idle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {in_ready, coeff_write, child_write, busy, tree_valid, err}, 64'd0);
    check({tag, "_addr"}, {coeff_addr, child_addr, node_count}, 64'd0);
    check({tag, "_coeff"}, coeff_data, 64'd0);
    check({tag, "_child"}, child_data, 64'd0);
  endtask

  initial begin : monitor
    bit   pb = 1'b0;
    bit   hp = 1'b0;
    int   cyc = 0;
    int   hc = 0;
    wr_t  w;
    out_t o;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pb = 1'b0;
        hp = 1'b0;
      end else begin
        if (busy && !pb) hp = 1'b1;
        if (hp && in_valid && in_ready) begin
          hc = cyc;
          hp = 1'b0;
        end
        if (coeff_write || child_write) begin
          if (wq.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_write: strobe at addr %0d, want no write", coeff_addr);
          end else begin
            w = wq.pop_front();
            check("write_strobes", {coeff_write, child_write, in_ready, busy}, 4'b1101);
            check("coeff_addr", coeff_addr, w.addr);
            check("child_addr", child_addr, w.addr);
            check("coeff_data", coeff_data, w.coeff);
            check("child_data", child_data, w.child);
          end
        end
        if (pb && !busy) begin
          if (oq.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_end: busy fell, want no load ending");
          end else begin
            o = oq.pop_front();
            check("status", {tree_valid, err, in_ready}, {o.done, o.err, 1'b0});
            if (o.done) check("node_count", node_count, o.n);
            if (o.lat != 0) check("latency", cyc - hc, o.lat);
          end
        end
        pb = busy;
      end
    end
  end

  initial begin : stimulus
    logic [7:0] s[$];
    int used;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single node, both children class leaves, full rate.
    s = {8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h02, 8'h01, 8'h80};
    add_trailer(s, 1'b0);
    run_load(s, 0, 1'b0);

    // Three nodes with in_valid toggling.
    build(3, 0, 1'b0, s);
    run_load(s, 1, 1'b0);

    // Rejected headers, then recovery.
    s = {8'h00};
    run_load(s, 0, 1'b0);
    s = {8'h41};
    run_load(s, 0, 1'b0);
    build(5, 0, 1'b0, s);
    run_load(s, 0, 1'b0);

    // Dangling pointer in node 0 of a 2-node tree.
    build(2, 0, 1'b0, s);
    s[7] = 8'h00; s[8] = 8'h04; s[9] = 8'h02;
    run_load(s, 0, 1'b0);

    // Reset in the middle of node 1's child bytes.
    build(4, 0, 1'b0, s);
    used = model(s, 1'b0);
    do_start();
    send(s, 17, 0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midreset");
    wq.delete();
    oq.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
    build(4, 0, 1'b0, s);
    run_load(s, 0, 1'b0);

`ifdef BDD_LOADER_CHECKSUM_EN
    build(1, 0, 1'b0, s);
    run_load(s, 0, 1'b0);
    build(1, 0, 1'b1, s);
    run_load(s, 0, 1'b0);
`endif

    for (int it = 0; it < 12; it++) begin
      int r;
      r = int'($urandom_range(9));
      if (r == 0) s = {8'($urandom_range(255, DEPTH + 1))};
      else if (r == 1) s = {8'h00};
`ifdef BDD_LOADER_CHECKSUM_EN
      else if (r == 2) build(int'($urandom_range(6, 1)), 0, 1'b1, s);
`endif
      else build(int'($urandom_range(12, 1)), 25, 1'b0, s);
      run_load(s, int'($urandom_range(2)), 1'($urandom_range(1)));
    end

    // Largest tree, full rate.
    build(DEPTH, 0, 1'b0, s);
    run_load(s, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("writes_drained", 64'(wq.size()), 64'd0);
    check("outcomes_drained", 64'(oq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
